pkt_decoder: RTL and testbench

- Parametrised successor of the UART command decoder.
- Parses framed byte packets: PREFIX, ADDR, DEST, LEN, DATA[LEN], CRC. Buffers the payload and, once the CRC is good, forwards it to one of N_DEST downstream channels with per-channel ready/valid backpressure.
- Over the original decoder it adds: input flow control, configurable CRC mode, destination and length validation, and error reporting.
- Sits between the UART receiver and the per-peripheral command sinks.

---
 rtl/pkt_decoder_pkg.sv | 29 ++
 rtl/pkt_decoder_fifo.sv | 55 +++++
 rtl/pkt_decoder.sv | 199 +++++++++++++++++++
 tb/tb_pkt_decoder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_decoder_pkg.sv
// Shared definitions for the packet decoder.
// Holds the FSM state encoding, the CRC mode selectors, the default frame
// constants and the per-byte CRC accumulation step used by the decoder.
package pkt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        AST,
        DEST,
        LEN,
        DATA,
        CRC,
        FORWARD
    } state_t;

    localparam int CRC_SUM = 0;
    localparam int CRC_XOR = 1;

    localparam logic [7:0] DEFAULT_PREFIX = 8'hAA;
    localparam logic [7:0] DEFAULT_ADDR   = 8'h01;

    // One accumulation step: modulo-256 sum or running XOR.
    function automatic logic [7:0] crc_step(input int mode, input logic [7:0] acc,
                                            input logic [7:0] b);
        if (mode == CRC_XOR) return acc ^ b;
        else                 return acc + b;
    endfunction

endpackage

// File: rtl/pkt_decoder_fifo.sv
// sync_fifo_fwft: first-word-fall-through synchronous FIFO.
// Ports:
//   clk, nrst   clock, synchronous active-low reset (pointers only)
//   sclr        synchronous clear, empties the FIFO
//   wr, din     write strobe and data (ignored when full)
//   rd          pop strobe (ignored when empty)
//   q           head of the FIFO, valid whenever empty is low
//   empty, full status flags
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             sclr,
    input  logic             wr,
    input  logic [WIDTH-1:0] din,
    input  logic             rd,
    output logic [WIDTH-1:0] q,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_wr;
    logic             do_rd;

    assign do_wr = wr && !full;
    assign do_rd = rd && !empty;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign q     = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!nrst || sclr) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_wr) wptr <= wptr + PTR_ONE;
            if (do_rd) rptr <= rptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/pkt_decoder.sv
// pkt_decoder: parses PREFIX, ADDR, DEST, LEN, DATA[LEN], CRC frames from a
// UART byte stream, buffers the payload and forwards it to one of N_DEST
// ready/valid channels once the CRC checks out.
// Ports:
//   clk, nrst          clock, synchronous active-low reset
//   rx_data, rx_valid  incoming byte stream; rx_ready is the accept handshake
//   q, valid_bus       forwarded byte and one-hot channel valid
//   ready_bus          per-channel sink ready (only the selected bit matters)
//   pkt_done           pulse with the last payload byte transfer
//   err_crc/dest/len/timeout  one-cycle error pulses
//   err_cnt            saturating error count
//   busy               decoder is not idle
module pkt_decoder
    import pkt_pkg::*;
#(
    parameter int         N_DEST     = 5,
    parameter int         FIFO_DEPTH = 256,
    parameter logic [7:0] PREFIX     = DEFAULT_PREFIX,
    parameter logic [7:0] ADDR       = DEFAULT_ADDR,
    parameter int         CRC_MODE   = CRC_SUM,
    parameter int         CLK_HZ     = 50000000,
    parameter int         TIMEOUT_MS = 10
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        q,
    output logic [N_DEST-1:0] valid_bus,
    input  logic [N_DEST-1:0] ready_bus,
    output logic              pkt_done,
    output logic              err_crc,
    output logic              err_dest,
    output logic              err_len,
    output logic              err_timeout,
    output logic [15:0]       err_cnt,
    output logic              busy
);

    localparam logic [31:0] CNT_LIMIT = 32'(CLK_HZ / 1000 * TIMEOUT_MS - 1);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t      state, state_nx;
    logic [7:0]  dest, dest_nx;
    logic [7:0]  len, len_nx;
    logic [7:0]  cnt, cnt_nx;
    logic [7:0]  crc, crc_nx;
    logic [31:0] tmo_cnt;

    logic              accept;
    logic              in_frame;
    logic              tmo_hit;
    logic              fwd_active;
    logic              fwd_pop;
    logic              err_any;
    logic [N_DEST-1:0] dest_hot;

    logic       fifo_wr, fifo_rd, fifo_sclr;
    logic [7:0] fifo_q;
    logic       fifo_empty, fifo_full;

    sync_fifo_fwft #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .nrst (nrst),
        .sclr (fifo_sclr),
        .wr   (fifo_wr),
        .din  (rx_data),
        .rd   (fifo_rd),
        .q    (fifo_q),
        .empty(fifo_empty),
        .full (fifo_full)
    );

    assign rx_ready   = (state != FORWARD);
    assign busy       = (state != IDLE);
    assign accept     = rx_valid && rx_ready;
    assign in_frame   = (state inside {AST, DEST, LEN, DATA, CRC});
    assign tmo_hit    = in_frame && (tmo_cnt == CNT_LIMIT);
    assign fwd_active = (state == FORWARD) && !fifo_empty;
    assign err_any    = err_crc || err_dest || err_len || err_timeout;

    always_comb begin
        dest_hot = '0;
        for (int i = 0; i < N_DEST; i++) dest_hot[i] = (int'(dest) == i);
    end

    // Only the selected channel's ready can pop; other sinks are ignored.
    assign fwd_pop   = fwd_active && |(ready_bus & dest_hot);
    assign valid_bus = fwd_active ? dest_hot : '0;
    assign q         = fwd_active ? fifo_q : 8'h00;

    always_comb begin
        state_nx    = state;
        dest_nx     = dest;
        len_nx      = len;
        cnt_nx      = cnt;
        crc_nx      = crc;
        fifo_wr     = 1'b0;
        fifo_rd     = 1'b0;
        fifo_sclr   = 1'b0;
        pkt_done    = 1'b0;
        err_crc     = 1'b0;
        err_dest    = 1'b0;
        err_len     = 1'b0;
        err_timeout = 1'b0;
        // A timeout overrides whatever byte arrives in the same cycle.
        if (tmo_hit) begin
            err_timeout = 1'b1;
            fifo_sclr   = 1'b1;
            crc_nx      = 8'h00;
            cnt_nx      = 8'h00;
            state_nx    = IDLE;
        end else begin
            case (state)
                IDLE: if (accept && rx_data == PREFIX) state_nx = AST;
                AST:  if (accept) state_nx = (rx_data == ADDR) ? DEST : IDLE;
                DEST: if (accept) begin
                    dest_nx  = rx_data;
                    state_nx = LEN;
                end
                LEN: if (accept) begin
                    if (rx_data == 8'd0 || int'(rx_data) > FIFO_DEPTH) begin
                        err_len  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        len_nx   = rx_data;
                        cnt_nx   = 8'h00;
                        state_nx = DATA;
                    end
                end
                DATA: if (accept) begin
                    fifo_wr = !fifo_full;
                    crc_nx  = crc_step(CRC_MODE, crc, rx_data);
                    if (cnt == len - 8'd1) begin
                        cnt_nx   = 8'h00;
                        state_nx = CRC;
                    end else begin
                        cnt_nx = cnt + 8'd1;
                    end
                end
                CRC: if (accept) begin
                    crc_nx = 8'h00;
                    if (int'(dest) >= N_DEST) begin
                        err_dest  = 1'b1;
                        fifo_sclr = 1'b1;
                        state_nx  = IDLE;
                    end else if (rx_data != crc) begin
                        err_crc   = 1'b1;
                        fifo_sclr = 1'b1;
                        state_nx  = IDLE;
                    end else begin
                        state_nx = FORWARD;
                    end
                end
                FORWARD: if (fwd_pop) begin
                    // cnt counts popped bytes so the last one is known
                    // without a FIFO occupancy counter.
                    fifo_rd = 1'b1;
                    if (cnt == len - 8'd1) begin
                        cnt_nx   = 8'h00;
                        pkt_done = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        cnt_nx = cnt + 8'd1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state   <= IDLE;
            dest    <= 8'h00;
            len     <= 8'h00;
            cnt     <= 8'h00;
            crc     <= 8'h00;
            tmo_cnt <= '0;
            err_cnt <= 16'h0000;
        end else begin
            state   <= state_nx;
            dest    <= dest_nx;
            len     <= len_nx;
            cnt     <= cnt_nx;
            crc     <= crc_nx;
            tmo_cnt <= (!in_frame || accept || tmo_hit) ? 32'd0 : tmo_cnt + 32'd1;
            if (err_any) err_cnt <= sat_inc(err_cnt);
        end
    end

endmodule

// File: tb/tb_pkt_decoder.sv
// Testbench for pkt_decoder: two instances (sum-CRC and XOR-CRC) share the
// stimulus; sel chooses which one receives bytes and is checked.
module tb_pkt_decoder;

    typedef logic [7:0] bq_t[$];

    localparam int K_OK   = 0;
    localparam int K_CRC  = 1;
    localparam int K_DEST = 2;
    localparam int K_LEN  = 3;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [4:0] ready_bus = 5'b0;
    logic       sel = 1'b0;

    logic        rx_valid0, rx_valid1;
    logic        rx_ready0, rx_ready1;
    logic [7:0]  q0, q1;
    logic [4:0]  vb0, vb1;
    logic        done0, done1, ecrc0, ecrc1, edst0, edst1, elen0, elen1, etmo0, etmo1;
    logic [15:0] ecnt0, ecnt1;
    logic        busy0, busy1;

    assign rx_valid0 = rx_valid && !sel;
    assign rx_valid1 = rx_valid && sel;

    logic        rx_ready_s, done_s, ecrc_s, edst_s, elen_s, etmo_s, busy_s;
    logic [7:0]  q_s;
    logic [4:0]  vb_s;
    logic [15:0] ecnt_s;
    assign rx_ready_s = sel ? rx_ready1 : rx_ready0;
    assign q_s        = sel ? q1 : q0;
    assign vb_s       = sel ? vb1 : vb0;
    assign done_s     = sel ? done1 : done0;
    assign ecrc_s     = sel ? ecrc1 : ecrc0;
    assign edst_s     = sel ? edst1 : edst0;
    assign elen_s     = sel ? elen1 : elen0;
    assign etmo_s     = sel ? etmo1 : etmo0;
    assign ecnt_s     = sel ? ecnt1 : ecnt0;
    assign busy_s     = sel ? busy1 : busy0;

    pkt_decoder #(.N_DEST(5), .FIFO_DEPTH(256), .CRC_MODE(0), .CLK_HZ(1000), .TIMEOUT_MS(20)) dut0 (
        .clk(clk), .nrst(nrst), .rx_data(rx_data), .rx_valid(rx_valid0), .rx_ready(rx_ready0),
        .q(q0), .valid_bus(vb0), .ready_bus(ready_bus), .pkt_done(done0), .err_crc(ecrc0),
        .err_dest(edst0), .err_len(elen0), .err_timeout(etmo0), .err_cnt(ecnt0), .busy(busy0));

    pkt_decoder #(.N_DEST(5), .FIFO_DEPTH(256), .CRC_MODE(1), .CLK_HZ(1000), .TIMEOUT_MS(20)) dut1 (
        .clk(clk), .nrst(nrst), .rx_data(rx_data), .rx_valid(rx_valid1), .rx_ready(rx_ready1),
        .q(q1), .valid_bus(vb1), .ready_bus(ready_bus), .pkt_done(done1), .err_crc(ecrc1),
        .err_dest(edst1), .err_len(elen1), .err_timeout(etmo1), .err_cnt(ecnt1), .busy(busy1));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_err[2] = '{0, 0};
    int seen_crc, seen_dest, seen_len, seen_tmo, seen_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: decide the fate of a frame from its bytes alone.
    function automatic void predict(input bq_t f, input int mode, output int kind,
                                    output int d, output bq_t pl);
        int n, acc;
        pl = {};
        d = int'(f[2]);
        n = int'(f[3]);
        kind = K_OK;
        if (n == 0) begin
            kind = K_LEN;
        end else begin
            acc = 0;
            for (int i = 0; i < n; i++) begin
                pl.push_back(f[4+i]);
                if (mode == 1) acc = acc ^ int'(f[4+i]);
                else           acc = (acc + int'(f[4+i])) % 256;
            end
            if (d >= 5)                     kind = K_DEST;
            else if (acc != int'(f[4+n]))   kind = K_CRC;
        end
    endfunction

    function automatic bq_t make_frame(input int mode);
        bq_t f;
        int d, n, acc;
        logic [7:0] b;
        d = $urandom_range(0, 6);
        n = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 8);
        f = {8'hAA, 8'h01, 8'(d), 8'(n)};
        if (n == 0) return f;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            f.push_back(b);
            acc = (mode == 1) ? (acc ^ int'(b)) : ((acc + int'(b)) % 256);
        end
        if ($urandom_range(0, 3) == 0) acc = acc ^ 8'h5A;
        f.push_back(8'(acc));
        return f;
    endfunction

    task automatic sample_pulses();
        seen_crc  += int'(ecrc_s);
        seen_dest += int'(edst_s);
        seen_len  += int'(elen_s);
        seen_tmo  += int'(etmo_s);
        seen_done += int'(done_s);
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) begin
            @(negedge clk);
            sample_pulses();
            chk("valid_outside_fwd", 32'(vb_s), 0);
            @(posedge clk); #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int  n = 0;
        bit  acc = 1'b0;
        bit  fin = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!fin) begin
            @(negedge clk);
            acc = rx_ready_s;
            sample_pulses();
            chk("valid_outside_fwd", 32'(vb_s), 0);
            @(posedge clk); #1;
            n++;
            if (acc) fin = 1'b1;
            else if (n >= 200) begin
                chk("rx_accept_bound", 0, 1);
                fin = 1'b1;
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic fwd(input bq_t pl, input int d, input int stall_at, input bit hold_next,
                       input bit rnd);
        int idx = 0, cyc = 0, stall = 0;
        logic [4:0] oh;
        bit rd;
        oh = 5'(1 << d);
        if (hold_next) begin
            rx_data  = 8'hAA;
            rx_valid = 1'b1;
        end
        while (idx < pl.size() && cyc < 1000) begin
            if (idx == stall_at && stall < 4) begin
                rd = 1'b0;
                stall++;
            end else begin
                rd = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            ready_bus = rnd ? 5'($urandom) : ~oh;
            ready_bus[d] = rd;
            @(negedge clk);
            chk("fwd_valid", 32'(vb_s), 32'(oh));
            chk("fwd_rx_ready", 32'(rx_ready_s), 0);
            chk("fwd_q", 32'(q_s), 32'(pl[idx]));
            chk("pkt_done", 32'(done_s), 32'(rd && idx == pl.size() - 1));
            if (rd) idx++;
            cyc++;
            @(posedge clk); #1;
        end
        if (idx < pl.size()) chk("fwd_complete", idx, pl.size());
        ready_bus = 5'b0;
    endtask

    task automatic run_frame(input bq_t f, input int gap_max, input int stall_at,
                             input bit hold_next, input bit rnd);
        int kind, d;
        bq_t pl;
        predict(f, int'(sel), kind, d, pl);
        seen_crc = 0; seen_dest = 0; seen_len = 0; seen_tmo = 0; seen_done = 0;
        for (int i = 0; i < f.size(); i++) begin
            if (i > 0 && gap_max > 0) idle($urandom_range(0, gap_max));
            send_byte(f[i]);
        end
        chk("err_crc_pulses", seen_crc, (kind == K_CRC) ? 1 : 0);
        chk("err_dest_pulses", seen_dest, (kind == K_DEST) ? 1 : 0);
        chk("err_len_pulses", seen_len, (kind == K_LEN) ? 1 : 0);
        chk("err_tmo_pulses", seen_tmo, 0);
        chk("early_pkt_done", seen_done, 0);
        if (kind == K_OK) fwd(pl, d, stall_at, hold_next, rnd);
        else exp_err[int'(sel)]++;
        chk("err_cnt", 32'(ecnt_s), exp_err[int'(sel)]);
        chk("busy_after_frame", 32'(busy_s), 0);
    endtask

    initial begin
        bq_t f;
        // Reset state of both instances.
        repeat (3) @(posedge clk);
        #1 nrst = 1'b1;
        @(negedge clk);
        chk("rst_valid0", 32'(vb0), 0);
        chk("rst_valid1", 32'(vb1), 0);
        chk("rst_rx_ready", 32'(rx_ready0), 1);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_q", 32'(q0), 0);
        chk("rst_err_cnt0", 32'(ecnt0), 0);
        chk("rst_err_cnt1", 32'(ecnt1), 0);
        chk("rst_pulses", 32'({done0, ecrc0, edst0, elen0, etmo0}), 0);
        @(posedge clk); #1;

        // Good frame, then the same frame with a mid-packet stall and a
        // back-to-back follower held on rx_valid during FORWARD.
        sel = 1'b0;
        f = {8'hAA, 8'h01, 8'h02, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
        run_frame(f, 0, -1, 1'b0, 1'b0);
        run_frame(f, 0, 1, 1'b1, 1'b0);
        run_frame(f, 0, -1, 1'b0, 1'b0);

        // Bad CRC followed by a good frame.
        run_frame({8'hAA, 8'h01, 8'h01, 8'h02, 8'h10, 8'h20, 8'h31}, 0, -1, 1'b0, 1'b0);
        run_frame({8'hAA, 8'h01, 8'h01, 8'h02, 8'h10, 8'h20, 8'h30}, 0, -1, 1'b0, 1'b0);

        // Bad destination, zero length, then a fresh prefix.
        run_frame({8'hAA, 8'h01, 8'h07, 8'h01, 8'h55, 8'h55}, 0, -1, 1'b0, 1'b0);
        run_frame({8'hAA, 8'h01, 8'h00, 8'h00}, 0, -1, 1'b0, 1'b0);
        run_frame({8'hAA, 8'h01, 8'h04, 8'h01, 8'h7E, 8'h7E}, 0, -1, 1'b0, 1'b0);

        // Inter-byte timeout inside DATA.
        seen_done = 0;
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h11);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            chk("tmo_pulse", 32'(etmo_s), (i == 20) ? 1 : 0);
            chk("tmo_busy", 32'(busy_s), 1);
            @(posedge clk); #1;
        end
        exp_err[0]++;
        chk("tmo_err_cnt", 32'(ecnt_s), exp_err[0]);
        chk("tmo_idle", 32'(busy_s), 0);
        run_frame(f, 0, -1, 1'b0, 1'b0);

        // Randomized frames, sum mode.
        for (int k = 0; k < 40; k++) run_frame(make_frame(0), 3, -1, 1'b0, 1'b1);

        // XOR mode.
        sel = 1'b1;
        for (int k = 0; k < 15; k++) run_frame(make_frame(1), 3, -1, 1'b0, 1'b1);
        run_frame({8'hAA, 8'h01, 8'h00, 8'h02, 8'h0F, 8'hF0, 8'h00}, 0, -1, 1'b0, 1'b0);
        run_frame({8'hAA, 8'h01, 8'h00, 8'h02, 8'h0F, 8'hF0, 8'hFF}, 0, -1, 1'b0, 1'b0);

        // Reset while forwarding.
        f = {8'hAA, 8'h01, 8'h00, 8'h02, 8'h0F, 8'hF0, 8'hFF};
        for (int i = 0; i < f.size(); i++) send_byte(f[i]);
        ready_bus = 5'b0;
        @(negedge clk);
        chk("xor_fwd_valid", 32'(vb_s), 1);
        chk("xor_fwd_q", 32'(q_s), 32'h0F);
        chk("pre_rst_err_cnt", 32'(ecnt_s), exp_err[1]);
        nrst = 1'b0;
        @(posedge clk); #1;
        nrst = 1'b1;
        chk("midrst_valid", 32'(vb_s), 0);
        chk("midrst_err_cnt", 32'(ecnt_s), 0);
        chk("midrst_busy", 32'(busy_s), 0);
        chk("midrst_rx_ready", 32'(rx_ready_s), 1);
        chk("midrst_q", 32'(q_s), 0);
        exp_err[0] = 0;
        exp_err[1] = 0;
        run_frame({8'hAA, 8'h01, 8'h03, 8'h02, 8'h3C, 8'hC3, 8'hFF}, 0, -1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
